// File: rtl/instruktions_dekodier_puffer.sv
// rtl/instruktions_dekodier_puffer.sv - buffered instruction decoder with valid/ready handshake and flush
//
// Purpose: queues fetched instruction words with their addresses in a FIFO of
// TIEFE entries and decodes the head entry into a registered output bundle.
//
// Ports:
//   Clock, Reset              clock (rising edge), asynchronous active-low reset
//   Instruktion, InstruktionAdresse, EingangGueltig / EingangBereit
//                             fetch side: word, address, valid / ready
//   Flush                     synchronous discard of everything buffered or presented
//   AusgangGueltig / AusgangAnnehmen
//                             consumer side: bundle valid / bundle taken
//   Fuellstand                FIFO entries, excluding the output register
//   AusgangAdresse .. BedingterSprungBefehl
//                             registered decoded fields of the presented instruction
module instruktions_dekodier_puffer #(
    parameter int TIEFE            = 4,
    parameter int ADRESS_BREITE    = 32,
    parameter int GLEITKOMMA_AKTIV = 1
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [31:0]                Instruktion,
    input  logic [ADRESS_BREITE-1:0]   InstruktionAdresse,
    input  logic                       EingangGueltig,
    output logic                       EingangBereit,
    input  logic                       Flush,
    output logic                       AusgangGueltig,
    input  logic                       AusgangAnnehmen,
    output logic [$clog2(TIEFE+1)-1:0] Fuellstand,
    output logic [ADRESS_BREITE-1:0]   AusgangAdresse,
    output logic [5:0]                 QuellRegister1,
    output logic [5:0]                 QuellRegister2,
    output logic [5:0]                 ZielRegister,
    output logic [25:0]                IDaten,
    output logic                       KleinerImmediateAktiv,
    output logic                       GrosserImmediateAktiv,
    output logic [5:0]                 FunktionsCode,
    output logic                       JALBefehl,
    output logic                       RelativerSprung,
    output logic                       AbsoluterSprung,
    output logic                       LoadBefehl,
    output logic                       StoreBefehl,
    output logic                       UnbedingterSprungBefehl,
    output logic                       BedingterSprungBefehl
);

    localparam int             FW      = $clog2(TIEFE + 1);
    localparam int             PW      = $clog2(TIEFE);
    localparam logic [FW-1:0]  VOLL    = FW'(TIEFE);
    localparam logic [PW-1:0]  LETZTER = PW'(TIEFE - 1);
    localparam logic           GK      = (GLEITKOMMA_AKTIV != 0);

    localparam logic [5:0] OP_LOAD  = 6'b101010;
    localparam logic [5:0] OP_LOADS = 6'b101011;
    localparam logic [5:0] OP_STORE = 6'b101100;
    localparam logic [5:0] OP_J     = 6'b101101;
    localparam logic [5:0] OP_BR    = 6'b101110;
    localparam logic [5:0] OP_JAL   = 6'b101111;
    localparam logic [5:0] OP_JREL  = 6'b010000;

    // FIFO storage and control
    logic [31:0]              speicher_instr [TIEFE];
    logic [ADRESS_BREITE-1:0] speicher_adr   [TIEFE];
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;
    logic                     aktiv;
    logic                     push;
    logic                     pop;

    // decode of the FIFO head
    logic [31:0] kopf;
    logic [5:0]  op;
    logic        r_format;
    logic        imm_format;
    logic        jmp_format;
    logic        fp;
    logic [5:0]  d_qr1;
    logic [5:0]  d_qr2;
    logic [5:0]  d_zr;
    logic [25:0] d_imm;
    logic [5:0]  d_fc;
    logic        d_jal;
    logic        d_rel;
    logic        d_abs;
    logic        d_ld;
    logic        d_st;
    logic        d_unb;
    logic        d_bed;

    function automatic logic [PW-1:0] weiter(input logic [PW-1:0] p);
        return (p == LETZTER) ? '0 : p + 1'b1;
    endfunction

    // aktiv stays low during reset and rises on the first edge after release,
    // so the fetch side only sees ready once the buffer is running.
    assign EingangBereit = aktiv & (Fuellstand != VOLL);

    always_comb begin
        push = EingangGueltig & EingangBereit & ~Flush;
        // The output register refills whenever it is empty or being taken.
        pop  = (~AusgangGueltig | AusgangAnnehmen) & (Fuellstand != '0) & ~Flush;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            aktiv          <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            Fuellstand     <= '0;
            AusgangGueltig <= 1'b0;
        end else begin
            aktiv <= 1'b1;
            if (Flush) begin
                wr_ptr         <= '0;
                rd_ptr         <= '0;
                Fuellstand     <= '0;
                AusgangGueltig <= 1'b0;
            end else begin
                if (push) wr_ptr <= weiter(wr_ptr);
                if (pop)  rd_ptr <= weiter(rd_ptr);
                case ({push, pop})
                    2'b10:   Fuellstand <= Fuellstand + 1'b1;
                    2'b01:   Fuellstand <= Fuellstand - 1'b1;
                    default: Fuellstand <= Fuellstand;
                endcase
                if (pop)
                    AusgangGueltig <= 1'b1;
                else if (AusgangAnnehmen)
                    AusgangGueltig <= 1'b0;
            end
        end
    end

    // Storage carries no reset; occupancy is tracked by the pointers alone.
    always_ff @(posedge Clock) begin
        if (push) begin
            speicher_instr[wr_ptr] <= Instruktion;
            speicher_adr[wr_ptr]   <= InstruktionAdresse;
        end
    end

    always_comb begin
        kopf       = speicher_instr[rd_ptr];
        op         = kopf[31:26];
        r_format   = (kopf[31:30] == 2'b00);
        imm_format = kopf[31];
        jmp_format = (kopf[31:30] == 2'b01);
        fp         = GK & r_format & (kopf[5:4] == 2'b10);

        d_qr1 = 6'd0;
        d_qr2 = 6'd0;
        d_zr  = 6'd0;
        d_imm = 26'd0;
        d_fc  = 6'd0;

        if (r_format)
            d_qr1 = {fp, kopf[20:16]};
        else if (imm_format)
            d_qr1 = {1'b0, kopf[20:16]};

        if (r_format)
            d_qr2 = {fp, kopf[15:11]};
        else if (op == OP_STORE)
            d_qr2 = {1'b0, kopf[25:21]};

        // LoadS targets the float bank when the bank bit is generated.
        if (r_format)
            d_zr = {fp, kopf[25:21]};
        else if (op == OP_LOADS)
            d_zr = {GK, kopf[25:21]};
        else if (imm_format)
            d_zr = {1'b0, kopf[25:21]};

        if (jmp_format)
            d_imm = kopf[25:0];
        else if (imm_format)
            d_imm = {{10{kopf[15]}}, kopf[15:0]};

        // Memory and control-flow opcodes carry no ALU function.
        if (r_format)
            d_fc = kopf[5:0];
        else if (jmp_format || (op >= OP_LOAD && op <= OP_JAL))
            d_fc = 6'd0;
        else
            d_fc = {1'b0, kopf[30:26]};

        d_jal = (op == OP_JAL);
        d_rel = (op == OP_JAL) | (op == OP_JREL) | (op == OP_BR);
        d_abs = (op == OP_J);
        d_ld  = (op == OP_LOAD) | (op == OP_LOADS);
        d_st  = (op == OP_STORE);
        d_unb = (op == OP_J) | (op == OP_JAL) | (op == OP_JREL);
        d_bed = (op == OP_BR);
    end

    // Decoded bundle; only reloaded on a pop, so it holds while stalled and
    // keeps stale contents after a flush.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            AusgangAdresse          <= '0;
            QuellRegister1          <= 6'd0;
            QuellRegister2          <= 6'd0;
            ZielRegister            <= 6'd0;
            IDaten                  <= 26'd0;
            KleinerImmediateAktiv   <= 1'b0;
            GrosserImmediateAktiv   <= 1'b0;
            FunktionsCode           <= 6'd0;
            JALBefehl               <= 1'b0;
            RelativerSprung         <= 1'b0;
            AbsoluterSprung         <= 1'b0;
            LoadBefehl              <= 1'b0;
            StoreBefehl             <= 1'b0;
            UnbedingterSprungBefehl <= 1'b0;
            BedingterSprungBefehl   <= 1'b0;
        end else if (pop) begin
            AusgangAdresse          <= speicher_adr[rd_ptr];
            QuellRegister1          <= d_qr1;
            QuellRegister2          <= d_qr2;
            ZielRegister            <= d_zr;
            IDaten                  <= d_imm;
            KleinerImmediateAktiv   <= imm_format;
            GrosserImmediateAktiv   <= jmp_format;
            FunktionsCode           <= d_fc;
            JALBefehl               <= d_jal;
            RelativerSprung         <= d_rel;
            AbsoluterSprung         <= d_abs;
            LoadBefehl              <= d_ld;
            StoreBefehl             <= d_st;
            UnbedingterSprungBefehl <= d_unb;
            BedingterSprungBefehl   <= d_bed;
        end
    end

endmodule

// File: tb/tb_instruktions_dekodier_puffer.sv
// tb/tb_instruktions_dekodier_puffer.sv - directed self-checking bench for instruktions_dekodier_puffer
module tb_instruktions_dekodier_puffer;

    localparam logic [5:0] OPS   [6] = '{6'h2F, 6'h10, 6'h2E, 6'h2D, 6'h2C, 6'h2B};
    // {jal, rel, abs, load, store, unb, bed}
    localparam logic [6:0] FLAGS [6] = '{7'b1100010, 7'b0100010, 7'b0100001,
                                         7'b0010010, 7'b0000100, 7'b0001000};
    localparam int         BP_F  [6] = '{1, 1, 2, 3, 4, 4};

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] a_instr, a_adr, a_out_adr;
    logic        a_in_v, a_in_r, a_flush, a_out_v, a_ann;
    logic [2:0]  a_fuell;
    logic [5:0]  a_qr1, a_qr2, a_zr, a_fc;
    logic [25:0] a_imm;
    logic        a_ki, a_gi, a_jal, a_rel, a_abs, a_ld, a_st, a_unb, a_bed;
    logic [6:0]  a_flags;
    assign a_flags = {a_jal, a_rel, a_abs, a_ld, a_st, a_unb, a_bed};

    logic [31:0] b_instr, b_adr, b_out_adr;
    logic        b_in_v, b_in_r, b_flush, b_out_v, b_ann;
    logic [1:0]  b_fuell;
    logic [5:0]  b_qr1, b_qr2, b_zr, b_fc;
    logic [25:0] b_imm;
    logic        b_ki, b_gi, b_jal, b_rel, b_abs, b_ld, b_st, b_unb, b_bed;

    instruktions_dekodier_puffer #(.TIEFE(4), .ADRESS_BREITE(32), .GLEITKOMMA_AKTIV(1)) dut_a (
        .Clock(clk), .Reset(rst_n), .Instruktion(a_instr), .InstruktionAdresse(a_adr),
        .EingangGueltig(a_in_v), .EingangBereit(a_in_r), .Flush(a_flush),
        .AusgangGueltig(a_out_v), .AusgangAnnehmen(a_ann), .Fuellstand(a_fuell),
        .AusgangAdresse(a_out_adr), .QuellRegister1(a_qr1), .QuellRegister2(a_qr2),
        .ZielRegister(a_zr), .IDaten(a_imm), .KleinerImmediateAktiv(a_ki),
        .GrosserImmediateAktiv(a_gi), .FunktionsCode(a_fc), .JALBefehl(a_jal),
        .RelativerSprung(a_rel), .AbsoluterSprung(a_abs), .LoadBefehl(a_ld),
        .StoreBefehl(a_st), .UnbedingterSprungBefehl(a_unb), .BedingterSprungBefehl(a_bed)
    );

    instruktions_dekodier_puffer #(.TIEFE(3), .ADRESS_BREITE(32), .GLEITKOMMA_AKTIV(0)) dut_b (
        .Clock(clk), .Reset(rst_n), .Instruktion(b_instr), .InstruktionAdresse(b_adr),
        .EingangGueltig(b_in_v), .EingangBereit(b_in_r), .Flush(b_flush),
        .AusgangGueltig(b_out_v), .AusgangAnnehmen(b_ann), .Fuellstand(b_fuell),
        .AusgangAdresse(b_out_adr), .QuellRegister1(b_qr1), .QuellRegister2(b_qr2),
        .ZielRegister(b_zr), .IDaten(b_imm), .KleinerImmediateAktiv(b_ki),
        .GrosserImmediateAktiv(b_gi), .FunktionsCode(b_fc), .JALBefehl(b_jal),
        .RelativerSprung(b_rel), .AbsoluterSprung(b_abs), .LoadBefehl(b_ld),
        .StoreBefehl(b_st), .UnbedingterSprungBefehl(b_unb), .BedingterSprungBefehl(b_bed)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_instr = '0; a_adr = '0; a_in_v = 1'b0; a_flush = 1'b0; a_ann = 1'b0;
        b_instr = '0; b_adr = '0; b_in_v = 1'b0; b_flush = 1'b0; b_ann = 1'b0;
        tick(); tick();
        n_cmp++; if (a_out_v !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", a_out_v); end
        n_cmp++; if (a_fuell !== 3'd0) begin n_fail++; $display("FAIL rst_fuell got %0d want 0", a_fuell); end
        n_cmp++; if (a_in_r !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b want 0", a_in_r); end
        n_cmp++; if (a_out_adr !== 32'h0) begin n_fail++; $display("FAIL rst_adr got %h want 0", a_out_adr); end
        n_cmp++; if ({a_zr, a_qr1, a_fc} !== 18'h0) begin n_fail++; $display("FAIL rst_fields got %h want 0", {a_zr, a_qr1, a_fc}); end
        n_cmp++; if (a_imm !== 26'h0) begin n_fail++; $display("FAIL rst_imm got %h want 0", a_imm); end
        #2 rst_n = 1'b1;
        tick();
        n_cmp++; if (a_in_r !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready_a got %b want 1", a_in_r); end
        n_cmp++; if (b_in_r !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready_b got %b want 1", b_in_r); end
    endtask

    task automatic test_immediate();
        a_instr = 32'h8C22_FFFC; a_adr = 32'h100; a_in_v = 1'b1; a_ann = 1'b1;
        tick();
        a_in_v = 1'b0;
        n_cmp++; if (a_out_v !== 1'b0) begin n_fail++; $display("FAIL imm_no_bypass got %b want 0", a_out_v); end
        n_cmp++; if (a_fuell !== 3'd1) begin n_fail++; $display("FAIL imm_fuell1 got %0d want 1", a_fuell); end
        tick();
        n_cmp++; if (a_out_v !== 1'b1) begin n_fail++; $display("FAIL imm_valid got %b want 1", a_out_v); end
        n_cmp++; if (a_out_adr !== 32'h100) begin n_fail++; $display("FAIL imm_adr got %h want 100", a_out_adr); end
        n_cmp++; if (a_imm !== 26'h3FFFFFC) begin n_fail++; $display("FAIL imm_idaten got %h want 3fffffc", a_imm); end
        n_cmp++; if (a_zr !== 6'h01) begin n_fail++; $display("FAIL imm_zr got %h want 01", a_zr); end
        n_cmp++; if (a_qr1 !== 6'h02) begin n_fail++; $display("FAIL imm_qr1 got %h want 02", a_qr1); end
        n_cmp++; if (a_fc !== 6'h03) begin n_fail++; $display("FAIL imm_fc got %h want 03", a_fc); end
        n_cmp++; if ({a_ki, a_gi} !== 2'b10) begin n_fail++; $display("FAIL imm_ki_gi got %b want 10", {a_ki, a_gi}); end
        n_cmp++; if (a_fuell !== 3'd0) begin n_fail++; $display("FAIL imm_fuell0 got %0d want 0", a_fuell); end
        tick();
        n_cmp++; if (a_out_v !== 1'b0) begin n_fail++; $display("FAIL imm_consumed got %b want 0", a_out_v); end
    endtask

    task automatic test_rformat();
        a_instr = 32'h0062_2020; a_adr = 32'h200; a_in_v = 1'b1; a_ann = 1'b1;
        b_instr = 32'h0062_2020; b_adr = 32'h200; b_in_v = 1'b1; b_ann = 1'b1;
        tick();
        a_in_v = 1'b0; b_in_v = 1'b0;
        tick();
        n_cmp++; if ({a_qr1, a_qr2, a_zr, a_fc} !== {6'h22, 6'h24, 6'h23, 6'h20})
            begin n_fail++; $display("FAIL rfmt_fp got %h %h %h %h want 22 24 23 20", a_qr1, a_qr2, a_zr, a_fc); end
        n_cmp++; if (b_out_v !== 1'b1) begin n_fail++; $display("FAIL rfmt_nofp_valid got %b want 1", b_out_v); end
        n_cmp++; if ({b_qr1, b_qr2, b_zr, b_fc} !== {6'h02, 6'h04, 6'h03, 6'h20})
            begin n_fail++; $display("FAIL rfmt_nofp got %h %h %h %h want 02 04 03 20", b_qr1, b_qr2, b_zr, b_fc); end
        tick();
    endtask

    task automatic test_opcodes();
        a_ann = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a_instr = {OPS[i], 26'h0001234}; a_adr = 32'h300 + 32'(i); a_in_v = 1'b1;
            tick();
            a_in_v = 1'b0;
            tick();
            n_cmp++; if (a_flags !== FLAGS[i]) begin n_fail++; $display("FAIL op_flags[%0d] got %b want %b", i, a_flags, FLAGS[i]); end
            n_cmp++; if (a_fc !== 6'h00) begin n_fail++; $display("FAIL op_fc[%0d] got %h want 00", i, a_fc); end
            n_cmp++; if (a_imm !== 26'h0001234) begin n_fail++; $display("FAIL op_imm[%0d] got %h want 0001234", i, a_imm); end
            if (i == 5) begin
                n_cmp++; if (a_zr !== 6'h20) begin n_fail++; $display("FAIL op_loads_zr got %h want 20", a_zr); end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        a_ann = 1'b1;
        for (int k = 0; k < 6; k++) begin
            a_instr = 32'(k + 8); a_adr = 32'h400 + 32'(4 * k); a_in_v = 1'b1;
            tick();
            if (k == 0) begin
                n_cmp++; if (a_out_v !== 1'b0) begin n_fail++; $display("FAIL b2b_first got %b want 0", a_out_v); end
            end else begin
                n_cmp++; if ({a_out_v, a_fc} !== {1'b1, 6'(k + 7)}) begin n_fail++; $display("FAIL b2b_word[%0d] got %b/%h want 1/%h", k, a_out_v, a_fc, 6'(k + 7)); end
                n_cmp++; if (a_out_adr !== 32'h400 + 32'(4 * (k - 1))) begin n_fail++; $display("FAIL b2b_adr[%0d] got %h", k, a_out_adr); end
                n_cmp++; if (a_fuell !== 3'd1) begin n_fail++; $display("FAIL b2b_fuell[%0d] got %0d want 1", k, a_fuell); end
            end
        end
        a_in_v = 1'b0;
        tick();
        n_cmp++; if ({a_out_v, a_fc, a_fuell} !== {1'b1, 6'd13, 3'd0}) begin n_fail++; $display("FAIL b2b_last got %b/%h/%0d want 1/0d/0", a_out_v, a_fc, a_fuell); end
        tick();
        n_cmp++; if (a_out_v !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b want 0", a_out_v); end
    endtask

    task automatic test_backpressure();
        a_ann = 1'b0;
        for (int k = 0; k < 6; k++) begin
            a_instr = 32'(k + 16); a_adr = 32'h500 + 32'(4 * k); a_in_v = 1'b1;
            tick();
            n_cmp++; if (a_fuell !== 3'(BP_F[k])) begin n_fail++; $display("FAIL bp_fuell[%0d] got %0d want %0d", k, a_fuell, BP_F[k]); end
            if (k >= 1) begin
                n_cmp++; if ({a_out_v, a_fc, a_out_adr} !== {1'b1, 6'd16, 32'h500})
                    begin n_fail++; $display("FAIL bp_hold[%0d] got %b/%h/%h want 1/10/500", k, a_out_v, a_fc, a_out_adr); end
            end
            if (k >= 4) begin
                n_cmp++; if (a_in_r !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d] got %b want 0", k, a_in_r); end
            end
        end
        a_in_v = 1'b0; a_ann = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            tick();
            n_cmp++; if ({a_out_v, a_fc} !== {1'b1, 6'(16 + j)}) begin n_fail++; $display("FAIL bp_drain[%0d] got %b/%h want 1/%h", j, a_out_v, a_fc, 6'(16 + j)); end
            n_cmp++; if (a_out_adr !== 32'h500 + 32'(4 * j)) begin n_fail++; $display("FAIL bp_drain_adr[%0d] got %h", j, a_out_adr); end
            n_cmp++; if (a_fuell !== 3'(4 - j)) begin n_fail++; $display("FAIL bp_drain_fuell[%0d] got %0d want %0d", j, a_fuell, 4 - j); end
        end
        tick();
        n_cmp++; if (a_out_v !== 1'b0) begin n_fail++; $display("FAIL bp_extra_dropped got %b want 0", a_out_v); end
    endtask

    task automatic test_flush();
        a_ann = 1'b0;
        for (int k = 0; k < 4; k++) begin
            a_instr = 32'(k + 32); a_adr = 32'h600 + 32'(4 * k); a_in_v = 1'b1;
            tick();
        end
        n_cmp++; if ({a_out_v, a_fuell} !== {1'b1, 3'd3}) begin n_fail++; $display("FAIL fl_pre got %b/%0d want 1/3", a_out_v, a_fuell); end
        a_instr = 32'h3F; a_adr = 32'h6F0; a_in_v = 1'b1; a_flush = 1'b1;
        tick();
        a_flush = 1'b0; a_in_v = 1'b0;
        n_cmp++; if ({a_out_v, a_fuell, a_in_r} !== {1'b0, 3'd0, 1'b1}) begin n_fail++; $display("FAIL fl_post got %b/%0d/%b want 0/0/1", a_out_v, a_fuell, a_in_r); end
        a_ann = 1'b1;
        tick(); tick();
        n_cmp++; if ({a_out_v, a_fuell} !== {1'b0, 3'd0}) begin n_fail++; $display("FAIL fl_lost got %b/%0d want 0/0", a_out_v, a_fuell); end
        a_instr = 32'h8C22_FFFC; a_adr = 32'h680; a_in_v = 1'b1;
        tick();
        a_in_v = 1'b0;
        tick();
        n_cmp++; if ({a_out_v, a_out_adr, a_imm} !== {1'b1, 32'h680, 26'h3FFFFFC}) begin n_fail++; $display("FAIL fl_after got %b/%h/%h want 1/680/3fffffc", a_out_v, a_out_adr, a_imm); end
        tick();
    endtask

    task automatic test_reset_midstream();
        a_ann = 1'b0;
        for (int k = 0; k < 2; k++) begin
            a_instr = 32'(k + 40); a_adr = 32'h700 + 32'(4 * k); a_in_v = 1'b1;
            tick();
        end
        a_in_v = 1'b0;
        n_cmp++; if ({a_out_v, a_fuell} !== {1'b1, 3'd1}) begin n_fail++; $display("FAIL mr_pre got %b/%0d want 1/1", a_out_v, a_fuell); end
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if ({a_out_v, a_fuell, a_in_r} !== {1'b0, 3'd0, 1'b0}) begin n_fail++; $display("FAIL mr_async got %b/%0d/%b want 0/0/0", a_out_v, a_fuell, a_in_r); end
        n_cmp++; if ({a_out_adr, a_fc} !== 38'h0) begin n_fail++; $display("FAIL mr_fields got %h/%h want 0/0", a_out_adr, a_fc); end
        tick();
        #2 rst_n = 1'b1;
        tick();
        n_cmp++; if (a_in_r !== 1'b1) begin n_fail++; $display("FAIL mr_ready got %b want 1", a_in_r); end
        a_instr = 32'h8C22_FFFC; a_adr = 32'h780; a_in_v = 1'b1; a_ann = 1'b1;
        tick();
        a_in_v = 1'b0;
        tick();
        n_cmp++; if ({a_out_v, a_out_adr, a_zr, a_qr1, a_fc} !== {1'b1, 32'h780, 6'h01, 6'h02, 6'h03})
            begin n_fail++; $display("FAIL mr_first got %b/%h/%h/%h/%h want 1/780/01/02/03", a_out_v, a_out_adr, a_zr, a_qr1, a_fc); end
        tick();
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_rformat();
        test_opcodes();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
